// File: rtl/cve2_rf_sb.sv
// Register file for the writeback port: 31 GPRs (x0 reads zero), two combinational
// read ports and a single-entry scoreboard that stalls ID on the outstanding load.

module cve2_rf_sb_rport #(
  parameter int unsigned DataWidth    = 32,
  parameter bit          WriteThrough = 1'b1
) (
  input  logic [31:0][DataWidth-1:0] rf,
  input  logic [4:0]                 raddr,
  input  logic                       ren,
  input  logic                       we,
  input  logic [4:0]                 waddr,
  input  logic [DataWidth-1:0]       wdata,
  input  logic                       pend_valid,
  input  logic [4:0]                 pend_addr,
  output logic [DataWidth-1:0]       rdata,
  output logic                       hit
);
  logic bypass;

  // rf[0] is tied to zero, so only the bypass needs an explicit x0 exclusion
  assign bypass = WriteThrough && we && (waddr != 5'd0) && (raddr == waddr);
  assign rdata  = bypass ? wdata : rf[raddr];
  assign hit    = pend_valid & ren & (raddr == pend_addr);
endmodule

module cve2_rf_sb #(
  parameter int unsigned          DataWidth    = 32,
  parameter bit                   WriteThrough = 1'b1,
  parameter logic [DataWidth-1:0] ResetValue   = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [4:0]           rf_waddr_wb_i,
  input  logic [DataWidth-1:0] rf_wdata_wb_i,
  input  logic                 rf_we_wb_i,
  input  logic                 rf_we_lsu_i,
  input  logic                 lsu_resp_valid_i,
  input  logic                 lsu_resp_err_i,
  input  logic [4:0]           rf_raddr_a_i,
  input  logic                 rf_ren_a_i,
  output logic [DataWidth-1:0] rf_rdata_a_o,
  input  logic [4:0]           rf_raddr_b_i,
  input  logic                 rf_ren_b_i,
  output logic [DataWidth-1:0] rf_rdata_b_o,
  input  logic [4:0]           id_waddr_i,
  input  logic                 id_we_i,
  input  logic                 load_issue_i,
  output logic                 hazard_stall_o,
  output logic                 load_pending_o,
  output logic                 sb_err_o
);
  localparam int unsigned NUM_RP = 2;

  logic [31:1][DataWidth-1:0]     regs_q;
  logic [31:0][DataWidth-1:0]     rf_view;
  logic [NUM_RP-1:0][4:0]         rp_addr;
  logic [NUM_RP-1:0]              rp_ren;
  logic [NUM_RP-1:0][DataWidth-1:0] rp_rdata;
  logic [NUM_RP-1:0]              rp_hit;

  logic       pend_valid_q;
  logic [4:0] pend_addr_q;
  logic       sb_err_q;
  logic       lsu_wb, clr_wb, clr_err, sb_clr, sb_set, sb_viol, eff_valid, waw_hit;

  // ---------------- storage ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      regs_q <= {31{ResetValue}};
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (rf_we_wb_i && (rf_waddr_wb_i == r[4:0])) regs_q[r] <= rf_wdata_wb_i;
      end
    end
  end

  assign rf_view = {regs_q, {DataWidth{1'b0}}};

  // ---------------- read ports ----------------
  assign rp_addr = {rf_raddr_b_i, rf_raddr_a_i};
  assign rp_ren  = {rf_ren_b_i, rf_ren_a_i};

  for (genvar p = 0; p < NUM_RP; p++) begin : g_rport
    cve2_rf_sb_rport #(
      .DataWidth    (DataWidth),
      .WriteThrough (WriteThrough)
    ) u_rport (
      .rf         (rf_view),
      .raddr      (rp_addr[p]),
      .ren        (rp_ren[p]),
      .we         (rf_we_wb_i),
      .waddr      (rf_waddr_wb_i),
      .wdata      (rf_wdata_wb_i),
      .pend_valid (eff_valid),
      .pend_addr  (pend_addr_q),
      .rdata      (rp_rdata[p]),
      .hit        (rp_hit[p])
    );
  end

  assign rf_rdata_a_o = rp_rdata[0];
  assign rf_rdata_b_o = rp_rdata[1];

  // ---------------- load scoreboard ----------------
  assign lsu_wb  = rf_we_wb_i & rf_we_lsu_i;
  assign clr_wb  = pend_valid_q & lsu_wb & (rf_waddr_wb_i == pend_addr_q);
  assign clr_err = pend_valid_q & lsu_resp_valid_i & lsu_resp_err_i;
  assign sb_clr  = clr_wb | clr_err;
  assign sb_set  = load_issue_i & (id_waddr_i != 5'd0);
  assign sb_viol = (sb_set & pend_valid_q & ~sb_clr) |
                   (pend_valid_q & lsu_wb & (rf_waddr_wb_i != pend_addr_q));

  // With bypass the clearing writeback already feeds ID, so the stall can drop now
  assign eff_valid = pend_valid_q & ~(WriteThrough & clr_wb);
  assign waw_hit   = eff_valid & id_we_i & (id_waddr_i == pend_addr_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 5'd0;
      sb_err_q     <= 1'b0;
    end else begin
      if (sb_set) begin
        pend_valid_q <= 1'b1;
        pend_addr_q  <= id_waddr_i;
      end else if (sb_clr) begin
        pend_valid_q <= 1'b0;
      end
      if (sb_viol) sb_err_q <= 1'b1;
    end
  end

  assign hazard_stall_o = (|rp_hit) | waw_hit;
  assign load_pending_o = pend_valid_q;
  assign sb_err_o       = sb_err_q;
endmodule

// File: doc/cve2_rf_sb.md
Name: cve2_rf_sb

Overview:
- Register-file endpoint for the writeback write port: consumes the single RF write (address/data/enable) driven by writeback and holds the 31 architectural GPRs (x0 hardwired to zero).
- Serves two combinational read ports to ID.
- Contains a single-entry load scoreboard that tracks the destination of the one outstanding LSU load. It raises a hazard stall to ID until the load's data is written back or the load terminates with an error.

Parameters:
- DataWidth, 32, GPR width in bits.
- WriteThrough, 1, 1 = a read of the register written this cycle returns the write data (bypass); 0 = returns the stored value.
- ResetValue, 32'h0, reset value of every GPR x1..x31.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  synchronous active-low reset
- rf_waddr_wb_i  input  5  writeback destination address
- rf_wdata_wb_i  input  DataWidth  writeback data
- rf_we_wb_i  input  1  writeback write enable
- rf_we_lsu_i  input  1  current writeback is load data (qualifies scoreboard clear)
- lsu_resp_valid_i  input  1  LSU response valid
- lsu_resp_err_i  input  1  LSU response error
- rf_raddr_a_i  input  5  read port A address
- rf_ren_a_i  input  1  read port A used by current ID instruction
- rf_rdata_a_o  output  DataWidth  read port A data
- rf_raddr_b_i  input  5  read port B address
- rf_ren_b_i  input  1  read port B used
- rf_rdata_b_o  output  DataWidth  read port B data
- id_waddr_i  input  5  destination of current ID instruction
- id_we_i  input  1  current ID instruction writes RF
- load_issue_i  input  1  ID issues a load this cycle (single-cycle pulse)
- hazard_stall_o  output  1  ID must hold the current instruction
- load_pending_o  output  1  scoreboard entry valid
- sb_err_o  output  1  sticky protocol error

Behaviour:
- Reset (rst_ni=0 sampled on a clk_i edge):
  - x1..x31 <= ResetValue.
  - pending_valid <= 0, pending_addr <= 0, sb_err_o <= 0.
  - Reset mid-load drops the pending entry, and no stall follows.
- Write:
  - On a rising edge with rf_we_wb_i=1 and rf_waddr_wb_i!=0, regs[rf_waddr_wb_i] <= rf_wdata_wb_i.
  - Writes to x0 are discarded.
  - Write data is visible in storage from the next cycle.
- Read (combinational, zero latency):
  - Address 0 always returns 0.
  - If WriteThrough=1, rf_we_wb_i=1 and raddr==rf_waddr_wb_i!=0, the port returns rf_wdata_wb_i. Otherwise it returns regs[raddr].
  - Both ports are independent; identical addresses are legal.
- Scoreboard set:
  - load_issue_i=1 with id_waddr_i!=0 sets pending_valid<=1 and pending_addr<=id_waddr_i on the next edge.
  - A load to x0 does not set the entry.
- Scoreboard clear: on an edge where pending_valid=1 and either
  - (a) rf_we_wb_i & rf_we_lsu_i & (rf_waddr_wb_i==pending_addr), or
  - (b) lsu_resp_valid_i & lsu_resp_err_i,
  
  the entry clears (pending_valid<=0).
- Simultaneous clear and issue in the same cycle: clear applies first, then set, so the new entry is valid with the new address.
- Issue while pending (with no same-cycle clear) is a protocol violation:
  - sb_err_o <= 1, sticky until reset.
  - The entry is overwritten with the new address.
- Load writeback with address != pending_addr: storage is written normally, the entry is not cleared, and sb_err_o <= 1.
- hazard_stall_o (combinational) = pending_valid & (
  - (rf_ren_a_i & rf_raddr_a_i==pending_addr) |
  - (rf_ren_b_i & rf_raddr_b_i==pending_addr) |
  - (id_we_i & id_waddr_i==pending_addr)).

  The last term is the WAW case.
- The stall deasserts in the same cycle as the clearing writeback, provided WriteThrough=1: the read returns the bypassed load data, so ID proceeds without a bubble. With WriteThrough=0 the stall is held one extra cycle, i.e. clear is evaluated on registered state.
- load_pending_o = pending_valid.

Test Plan:
- Reset, then read x0..x31 on both ports -> all 0 (ResetValue=0); hazard_stall_o=0, sb_err_o=0.
- Write x5=32'hDEADBEEF and x0=32'h1234 -> next cycle A(x5)=32'hDEADBEEF, B(x0)=0. Same-cycle read of x5 during the write returns 32'hDEADBEEF when WriteThrough=1, and the old value when WriteThrough=0.
- Issue load to x7, then ID reads A=x7 -> stall=1 for 3 cycles. LSU writeback x7=32'hA5A5A5A5 (rf_we_lsu_i=1) -> stall=0 that cycle, A returns 32'hA5A5A5A5, load_pending_o=0 next cycle.
- Issue load to x9, then LSU response with err=1 and no write -> entry clears, stall drops, x9 unchanged.
- Load writeback to x3 and new load issue to x4 in the same cycle -> pending_addr=4 and valid, sb_err_o=0. A second issue without completion -> sb_err_o=1, sticky.
- Reset asserted while pending x12 and stalling -> stall=0 and load_pending_o=0 after the reset edge, and all GPRs reset.
